// File: rtl/sigmoid_argmax.sv
// Argmax classifier over N IEEE-754 single-precision activations.
// Scans one buffered element per cycle and reports the index and bit pattern of the largest one.
module sigmoid_argmax #(
  parameter int unsigned S  = 32,
  parameter int unsigned N  = 4,
  parameter int unsigned IW = ($clog2(N) > 0 ? $clog2(N) : 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [S*N-1:0]   x,
  output logic [IW-1:0]    idx,
  output logic [S-1:0]     max_val,
  output logic             done,
  output logic             busy
);

  // One extra counter bit so cnt can reach N without wrapping at powers of two
  localparam int unsigned CW = IW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Ordering key: NaN maps to zero, every other value sits above it in IEEE order
  function automatic logic [S:0] rank_key(input logic [S-1:0] v);
    logic is_nan;
    is_nan = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    if (is_nan)
      rank_key = '0;
    else if (v[S-1])
      rank_key = {1'b1, ~v};
    else
      rank_key = {1'b1, v ^ {1'b1, {(S-1){1'b0}}}};
  endfunction

  logic [1:0]      state_q,    state_n;
  logic [S*N-1:0]  x_buf_q,    x_buf_n;
  logic [S-1:0]    best_val_q, best_val_n;
  logic [IW-1:0]   best_idx_q, best_idx_n;
  logic [CW-1:0]   cnt_q,      cnt_n;
  logic [IW-1:0]   idx_n;
  logic [S-1:0]    max_val_n;
  logic            done_n;
  logic            busy_n;
  logic [S-1:0]    cur_elem;

  // Element currently addressed by the scan counter
  always_comb begin
    cur_elem = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt_q == CW'(i))
        cur_elem = x_buf_q[S*i +: S];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n    = state_q;
    x_buf_n    = x_buf_q;
    best_val_n = best_val_q;
    best_idx_n = best_idx_q;
    cnt_n      = cnt_q;
    idx_n      = idx;
    max_val_n  = max_val;
    done_n     = 1'b0;
    busy_n     = busy;

    case (state_q)
      ST_IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          x_buf_n    = x;
          best_val_n = x[S-1:0];
          best_idx_n = '0;
          cnt_n      = CW'(1);
          busy_n     = 1'b1;
          state_n    = (N > 1) ? ST_SCAN : ST_FIN;
        end
      end

      ST_SCAN: begin
        // Strictly greater: ties keep the lower index
        if (rank_key(cur_elem) > rank_key(best_val_q)) begin
          best_val_n = cur_elem;
          best_idx_n = cnt_q[IW-1:0];
        end
        cnt_n = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1))
          state_n = ST_FIN;
      end

      ST_FIN: begin
        idx_n     = best_idx_q;
        max_val_n = best_val_q;
        done_n    = 1'b1;
        busy_n    = 1'b0;
        state_n   = ST_IDLE;
      end

      default: begin
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      x_buf_q    <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      idx        <= '0;
      max_val    <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_n;
      x_buf_q    <= x_buf_n;
      best_val_q <= best_val_n;
      best_idx_q <= best_idx_n;
      cnt_q      <= cnt_n;
      idx        <= idx_n;
      max_val    <= max_val_n;
      done       <= done_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_sigmoid_argmax.sv
// Bench for sigmoid_argmax: N=4 and N=1 instances checked every cycle against a
// transaction-level model that ranks activations by their numeric float value.
module tb_sigmoid_argmax;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start4, start1;
  logic [127:0] x4;
  logic [31:0]  x1;
  logic [1:0]   idx4;
  logic [31:0]  mv4;
  logic         done4, busy4;
  logic [0:0]   idx1;
  logic [31:0]  mv1;
  logic         done1, busy1;

  sigmoid_argmax #(.S(32), .N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .x(x4),
    .idx(idx4), .max_val(mv4), .done(done4), .busy(busy4)
  );

  sigmoid_argmax #(.S(32), .N(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .x(x1),
    .idx(idx1), .max_val(mv1), .done(done1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Numeric value of a non-NaN float; infinities pushed beyond any finite value
  function automatic real fval(input logic [31:0] v);
    real mag;
    int  ex;
    ex = int'(v[30:23]);
    if (ex == 255)
      mag = 1.0e300;
    else if (ex == 0)
      mag = real'(v[22:0]) * (2.0 ** -149.0);
    else
      mag = (1.0 + real'(v[22:0]) / 8388608.0) * (2.0 ** real'(ex - 127));
    return v[31] ? -mag : mag;
  endfunction

  // a outranks b: NaN lowest, numeric order otherwise, +0 above -0
  function automatic bit greater(input logic [31:0] a, input logic [31:0] b);
    real ra, rb;
    if (is_nan(a)) return 1'b0;
    if (is_nan(b)) return 1'b1;
    ra = fval(a);
    rb = fval(b);
    if (ra > rb) return 1'b1;
    if (ra < rb) return 1'b0;
    return (a == 32'h0000_0000) && (b == 32'h8000_0000);
  endfunction

  function automatic int argmax_ref(input logic [31:0] e [4], input int n);
    int bi;
    bi = 0;
    for (int i = 1; i < n; i++)
      if (greater(e[i], e[bi])) bi = i;
    return bi;
  endfunction

  function automatic logic [31:0] rnd_elem();
    logic [31:0] pool [4];
    pool[0] = 32'h3F00_0000; pool[1] = 32'h3F80_0000;
    pool[2] = 32'hBF80_0000; pool[3] = 32'h7FC0_0000;
    case ($urandom_range(0, 8))
      0: return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 8388607))};
      1: return 32'h0000_0000;
      2: return 32'h8000_0000;
      3: return 32'h7F80_0000;
      4: return 32'hFF80_0000;
      5, 6: return pool[$urandom_range(0, 3)];
      default: return $urandom;
    endcase
  endfunction

  // Transaction model, N=4: remaining-cycle counter plus precomputed result
  int          m4_rem;
  int          m4_pidx;
  logic [31:0] m4_pval;
  logic [31:0] exp4_idx, exp4_val;
  logic        exp4_done, exp4_busy;
  bit          armed = 1'b0;

  always @(posedge clk) begin : model4
    logic [31:0] e [4];
    if (rst) begin
      m4_rem = 0; exp4_idx = 0; exp4_val = 0; exp4_done = 0; exp4_busy = 0;
      armed = 1'b1;
    end else begin
      exp4_done = 1'b0;
      if (m4_rem == 0) begin
        if (start4) begin
          for (int i = 0; i < 4; i++) e[i] = x4[32*i +: 32];
          m4_pidx   = argmax_ref(e, 4);
          m4_pval   = e[m4_pidx];
          m4_rem    = 4;
          exp4_busy = 1'b1;
        end
      end else begin
        m4_rem--;
        if (m4_rem == 0) begin
          exp4_done = 1'b1;
          exp4_busy = 1'b0;
          exp4_idx  = 32'(m4_pidx);
          exp4_val  = m4_pval;
        end
      end
    end
  end

  // Transaction model, N=1
  int          m1_rem;
  logic [31:0] m1_pval;
  logic [31:0] exp1_val;
  logic        exp1_done, exp1_busy;

  always @(posedge clk) begin : model1
    if (rst) begin
      m1_rem = 0; exp1_val = 0; exp1_done = 0; exp1_busy = 0;
    end else begin
      exp1_done = 1'b0;
      if (m1_rem == 0) begin
        if (start1) begin
          m1_pval   = x1;
          m1_rem    = 1;
          exp1_busy = 1'b1;
        end
      end else begin
        m1_rem--;
        if (m1_rem == 0) begin
          exp1_done = 1'b1;
          exp1_busy = 1'b0;
          exp1_val  = m1_pval;
        end
      end
    end
  end

  // Cycle-by-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      chk("done4",  32'(done4), 32'(exp4_done));
      chk("busy4",  32'(busy4), 32'(exp4_busy));
      chk("idx4",   32'(idx4),  exp4_idx);
      chk("val4",   mv4,        exp4_val);
      chk("done1",  32'(done1), 32'(exp1_done));
      chk("busy1",  32'(busy1), 32'(exp1_busy));
      chk("idx1",   32'(idx1),  32'd0);
      chk("val1",   mv1,        exp1_val);
    end
  end

  task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [31:0] d, input int lit_idx, input logic [31:0] lit_val);
    logic [31:0] e [4];
    int k;
    e[0] = a; e[1] = b; e[2] = c; e[3] = d;
    chk("model_pin_idx", 32'(argmax_ref(e, 4)), 32'(lit_idx));
    @(negedge clk);
    x4 = {d, c, b, a};
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    x4 = '0;
    k = 0;
    while (!done4 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!done4) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("lit_idx", 32'(idx4), 32'(lit_idx));
      chk("lit_val", mv4, lit_val);
      chk("latency", 32'(k), 32'd4);
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; start4 = 1'b0; start1 = 1'b0; x4 = '0; x1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_idx",  32'(idx4), 32'd0);
    chk("rst_val",  mv4, 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);

    run4(32'h3F40_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h3E80_0000, 2, 32'h3F80_0000);
    run4(32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 0, 32'h3F00_0000);
    run4(32'hC073_3333, 32'hBF80_0000, 32'h8000_0000, 32'hC0A0_0000, 2, 32'h8000_0000);
    run4(32'h7FC0_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hFF80_0000, 1, 32'hBF80_0000);
    run4(32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 0, 32'h7FC0_0000);
    run4(32'h8000_0000, 32'h0000_0000, 32'hFF80_0000, 32'h7F80_0000, 3, 32'h7F80_0000);

    // Second start with new data mid-scan is ignored
    @(negedge clk);
    x4 = {32'h3E80_0000, 32'h3F80_0000, 32'h3F00_0000, 32'h3F40_0000};
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    x4 = {32'h0, 32'h0, 32'h0, 32'h4000_0000};
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (done4) begin
        n++;
        chk("ignored_start_idx", 32'(idx4), 32'd2);
        chk("ignored_start_val", mv4, 32'h3F80_0000);
      end
    end
    chk("single_done", 32'(n), 32'd1);

    // Reset mid-scan abandons the result
    @(negedge clk);
    x4 = {32'h3E80_0000, 32'h3F80_0000, 32'h3F00_0000, 32'h3F40_0000};
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_idx",  32'(idx4), 32'd0);
    chk("midrst_val",  mv4, 32'd0);
    chk("midrst_busy", 32'(busy4), 32'd0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (done4) n++;
    end
    chk("no_done_after_rst", 32'(n), 32'd0);
    run4(32'h3F40_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h3E80_0000, 2, 32'h3F80_0000);

    // N=1 with start held high: one result every two cycles
    @(negedge clk);
    x1 = 32'h40A0_0000;
    start1 = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done1) begin
        n++;
        chk("n1_idx", 32'(idx1), 32'd0);
        chk("n1_val", mv1, 32'h40A0_0000);
      end
    end
    start1 = 1'b0;
    chk("n1_done_count", 32'(n), 32'd10);

    // N=4 with start held high: one result every five cycles
    @(negedge clk);
    x4 = {32'h3F00_0000, 32'h7F80_0000, 32'h3F00_0000, 32'h0};
    start4 = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done4) n++;
    end
    start4 = 1'b0;
    chk("n4_done_count", 32'(n), 32'd4);
    repeat (6) @(negedge clk);

    // Randomized traffic, checked cycle by cycle against the model
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) x4[32*i +: 32] = rnd_elem();
      x1     = rnd_elem();
      start4 = ($urandom_range(0, 2) == 0);
      start1 = ($urandom_range(0, 1) == 0);
      rst    = ($urandom_range(0, 80) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start4 = 1'b0; start1 = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
